// File: rtl/uart_echo_fifo.sv
// uart_echo_fifo: buffered UART loopback. Received frames are checked
// (optional parity, stop bit); good payloads are queued in a FIFO and
// retransmitted in arrival order. Status is reported on the LED outputs.
//
// Internal handshake: push is a one-cycle strobe from the rx FSM, pop a
// one-cycle strobe from the tx FSM. A push is written when the FIFO is not
// full or a pop happens in the same cycle. A pop is only issued when the
// FIFO is non-empty, so it always reads valid data.
module uart_echo_fifo #(
  parameter int CLK_HZ       = 12000000,
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = 8,
  parameter int PARITY       = 0,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_pin,
  output logic       tx_pin,
  output logic [7:0] left_leds,
  output logic [4:0] right_leds,
  output logic [2:0] rx_state_dbg,
  output logic [2:0] tx_state_dbg
);

  localparam int CPB  = CLK_HZ / BIT_RATE;
  localparam int HALF = CPB / 2;
  localparam int CW   = $clog2(CPB);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam logic          PAR_ODD  = (PARITY == 2);
  localparam logic          PAR_EN   = (PARITY != 0);
  localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
  localparam logic [2:0]    BIT_LAST = 3'(PAYLOAD_BITS - 1);

  typedef enum logic [2:0] {
    R_IDLE, R_START, R_DATA, R_PARITY, R_STOP, R_BREAK
  } rx_state_t;

  typedef enum logic [2:0] {
    T_IDLE, T_START, T_DATA, T_PARITY, T_STOP
  } tx_state_t;

  // Synchroniser
  logic rx_meta, rx_sync;

  // Receiver
  rx_state_t               rx_state, rx_state_n;
  logic [CW-1:0]           rx_cnt;
  logic [2:0]              rx_bit;
  logic [PAYLOAD_BITS-1:0] rx_shift;
  logic                    rx_par_bad;
  logic                    rx_half, rx_tick;
  logic                    push, set_frame_err, set_parity_err;

  // FIFO
  logic [PAYLOAD_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW:0]             wr_ptr, rd_ptr, count;
  logic                    full, empty, wr_en;
  logic [PAYLOAD_BITS-1:0] rd_data;

  // Transmitter
  tx_state_t               tx_state, tx_state_n;
  logic [CW-1:0]           tx_cnt;
  logic [2:0]              tx_bit;
  logic [PAYLOAD_BITS-1:0] tx_shift;
  logic                    tx_par, tx_tick, tx_pin_n, tx_pin_q, pop;

  // Stall point that holds queued bytes in the FIFO; inactive in normal use.
  logic pop_stall;
  assign pop_stall = 1'b0;

  // Status
  logic overflow, frame_err, parity_err;

  // Two-flop synchroniser on the asynchronous rx line, idles high.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx_pin;
      rx_sync <= rx_meta;
    end
  end

  assign rx_half = (rx_cnt == CNT_HALF);
  assign rx_tick = (rx_cnt == CNT_LAST);

  // Receiver next-state and accept/reject strobes.
  always_comb begin
    rx_state_n     = rx_state;
    push           = 1'b0;
    set_frame_err  = 1'b0;
    set_parity_err = 1'b0;
    case (rx_state)
      R_IDLE:   if (!rx_sync) rx_state_n = R_START;
      R_START:  if (rx_half) rx_state_n = rx_sync ? R_IDLE : R_DATA;
      R_DATA:   if (rx_tick && rx_bit == BIT_LAST) rx_state_n = PAR_EN ? R_PARITY : R_STOP;
      R_PARITY: if (rx_tick) rx_state_n = R_STOP;
      R_STOP: begin
        if (rx_tick) begin
          if (rx_sync) begin
            rx_state_n = R_IDLE;
            if (rx_par_bad) set_parity_err = 1'b1;
            else            push           = 1'b1;
          end else begin
            // Bad stop (including a break): wait for the line to go high.
            rx_state_n    = R_BREAK;
            set_frame_err = 1'b1;
          end
        end
      end
      R_BREAK:  if (rx_sync) rx_state_n = R_IDLE;
      default:  rx_state_n = R_IDLE;
    endcase
  end

  // Receiver registers: baud counter reloads on every bit boundary or state change.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_state   <= R_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
      rx_par_bad <= 1'b0;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= (rx_state_n != rx_state || rx_tick) ? '0 : rx_cnt + 1'b1;
      if (rx_state == R_IDLE) begin
        rx_bit     <= '0;
        rx_par_bad <= 1'b0;
      end
      if (rx_state == R_DATA && rx_tick) begin
        rx_shift <= {rx_sync, rx_shift[PAYLOAD_BITS-1:1]};
        rx_bit   <= rx_bit + 1'b1;
      end
      if (rx_state == R_PARITY && rx_tick)
        rx_par_bad <= rx_sync != (^rx_shift ^ PAR_ODD);
    end
  end

  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign wr_en   = push && (!full || pop);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // FIFO storage; contents are meaningless once the pointers are reset.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= rx_shift;
  end

  // FIFO pointers, sticky status flags and the last-accepted payload.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      left_leds  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (push && full && !pop) overflow <= 1'b1;
      if (set_frame_err)  frame_err  <= 1'b1;
      if (set_parity_err) parity_err <= 1'b1;
      if (push) left_leds <= 8'(rx_shift);
    end
  end

  assign tx_tick = (tx_cnt == CNT_LAST);

  // Transmitter next-state, pop strobe and next line level.
  always_comb begin
    tx_state_n = tx_state;
    pop        = 1'b0;
    tx_pin_n   = tx_pin_q;
    case (tx_state)
      T_IDLE: begin
        if (!empty && !pop_stall) begin
          pop        = 1'b1;
          tx_state_n = T_START;
        end
      end
      T_START:  if (tx_tick) tx_state_n = T_DATA;
      T_DATA:   if (tx_tick && tx_bit == BIT_LAST) tx_state_n = PAR_EN ? T_PARITY : T_STOP;
      T_PARITY: if (tx_tick) tx_state_n = T_STOP;
      T_STOP: begin
        if (tx_tick) begin
          // Chain straight into the next queued byte with no idle gap.
          if (!empty && !pop_stall) begin
            pop        = 1'b1;
            tx_state_n = T_START;
          end else begin
            tx_state_n = T_IDLE;
          end
        end
      end
      default: tx_state_n = T_IDLE;
    endcase
    if (tx_state == T_IDLE || tx_tick) begin
      case (tx_state_n)
        T_START:  tx_pin_n = 1'b0;
        T_DATA:   tx_pin_n = (tx_state == T_DATA) ? tx_shift[1] : tx_shift[0];
        T_PARITY: tx_pin_n = tx_par;
        default:  tx_pin_n = 1'b1;
      endcase
    end
  end

  // Transmitter registers; the line level is registered so it is glitch-free.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_state <= T_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      tx_pin_q <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_pin_q <= tx_pin_n;
      tx_cnt   <= (tx_state == T_IDLE || tx_tick) ? '0 : tx_cnt + 1'b1;
      if (pop) begin
        tx_shift <= rd_data;
        tx_par   <= ^rd_data ^ PAR_ODD;
        tx_bit   <= '0;
      end else if (tx_state == T_DATA && tx_tick) begin
        tx_shift <= tx_shift >> 1;
        tx_bit   <= tx_bit + 1'b1;
      end
    end
  end

  assign tx_pin       = tx_pin_q;
  assign right_leds   = {overflow, frame_err, parity_err, full, empty};
  assign rx_state_dbg = rx_state;
  assign tx_state_dbg = tx_state;

endmodule

// File: tb/tb_uart_echo_fifo.sv
// tb_uart_echo_fifo: two instances (8N1 and 8E1, FIFO depth 4, CPB = 10).
// Directed frames are driven on the rx pins; expected echoes go into a
// queue per instance and a serial monitor on each tx pin pops and compares.
module tb_uart_echo_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx0, rx1, tx0, tx1;
  logic [7:0] ll0, ll1;
  logic [4:0] rl0, rl1;
  logic [2:0] rs0, ts0, rs1, ts1;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  int  echo_cnt[2];
  bit  mon_busy[2];
  int  last_start[2];

  uart_echo_fifo #(.CLK_HZ(1000000), .BIT_RATE(100000), .PAYLOAD_BITS(8),
                   .PARITY(0), .FIFO_DEPTH(4)) dut (
    .clock(clk), .reset(rst_n), .rx_pin(rx0), .tx_pin(tx0),
    .left_leds(ll0), .right_leds(rl0), .rx_state_dbg(rs0), .tx_state_dbg(ts0));

  uart_echo_fifo #(.CLK_HZ(1000000), .BIT_RATE(100000), .PAYLOAD_BITS(8),
                   .PARITY(1), .FIFO_DEPTH(4)) dut_p (
    .clock(clk), .reset(rst_n), .rx_pin(rx1), .tx_pin(tx1),
    .left_leds(ll1), .right_leds(rl1), .rx_state_dbg(rs1), .tx_state_dbg(ts1));

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic get_tx(input int w);
    return (w == 0) ? tx0 : tx1;
  endfunction

  function automatic int q_size(input int w);
    return (w == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  task automatic set_rx(input int w, input logic v);
    if (w == 0) rx0 = v;
    else        rx1 = v;
  endtask

  // Driver: one frame, 10 cycles per bit; parity bit only on the 8E1 instance.
  task automatic send_byte(input int w, input logic [7:0] d, input logic par_flip,
                           input logic stop);
    set_rx(w, 1'b0);
    repeat (10) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      set_rx(w, d[i]);
      repeat (10) @(negedge clk);
    end
    if (w == 1) begin
      set_rx(w, (^d) ^ par_flip);
      repeat (10) @(negedge clk);
    end
    set_rx(w, stop);
    repeat (10) @(negedge clk);
    set_rx(w, 1'b1);
  endtask

  // Monitor: decode each frame on a tx pin and check it against the queue.
  task automatic monitor(input int w);
    logic [7:0] d;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && get_tx(w) == 1'b0) begin
        mon_busy[w]   = 1'b1;
        last_start[w] = cyc;
        repeat (5) @(negedge clk);
        check("echo_start_bit", 32'(get_tx(w)), 0);
        for (int i = 0; i < 8; i++) begin
          repeat (10) @(negedge clk);
          d[i] = get_tx(w);
        end
        if (w == 1) begin
          repeat (10) @(negedge clk);
          check("echo_parity", 32'(get_tx(w)), 32'(^d));
        end
        repeat (10) @(negedge clk);
        check("echo_stop_bit", 32'(get_tx(w)), 1);
        echo_cnt[w]++;
        n_checks++;
        if (q_size(w) == 0) begin
          n_fail++;
          $display("FAIL echo_unexpected inst %0d: got %0h, required no echo", w, d);
        end else begin
          e = (w == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          if (d !== e) begin
            n_fail++;
            $display("FAIL echo_data inst %0d: got %0h, required %0h", w, d, e);
          end
        end
        mon_busy[w] = 1'b0;
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  // Bounded wait for all expected echoes on one instance.
  task automatic wait_drain(input int w, input int budget);
    int n = 0;
    while ((q_size(w) != 0 || mon_busy[w]) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 32'(q_size(w)), 0);
    repeat (10) @(negedge clk);
  endtask

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    int k;
    int e0;
    int e1;
    rst_n = 1'b0;
    rx0   = 1'b1;
    rx1   = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_tx_pin", 32'(tx0), 1);
    check("reset_left_leds", 32'(ll0), 0);
    check("reset_right_leds", 32'(rl0), 5'b00001);
    check("reset_right_leds_p", 32'(rl1), 5'b00001);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single byte 0xA5: start bit appears 99 cycles after the start edge
    k = cyc;
    exp_q0.push_back(8'hA5);
    send_byte(0, 8'hA5, 1'b0, 1'b1);
    wait_drain(0, 300);
    check("tx_start_latency", 32'(last_start[0] - k), 99);
    check("left_leds_a5", 32'(ll0), 8'hA5);
    check("status_after_a5", 32'(rl0), 5'b00001);

    // 20 back-to-back bytes through a 4-deep FIFO: no loss
    e0 = echo_cnt[0];
    for (int i = 0; i < 20; i++) begin
      exp_q0.push_back(8'(i));
      send_byte(0, 8'(i), 1'b0, 1'b1);
    end
    wait_drain(0, 500);
    check("burst_echo_count", 32'(echo_cnt[0] - e0), 20);
    check("burst_status", 32'(rl0), 5'b00001);

    // Pops stalled after the first byte: 6th queued byte overflows
    e0 = echo_cnt[0];
    exp_q0.push_back(8'h20);
    send_byte(0, 8'h20, 1'b0, 1'b1);
    force dut.pop_stall = 1'b1;
    for (int i = 1; i < 5; i++) begin
      exp_q0.push_back(8'(8'h20 + i));
      send_byte(0, 8'(8'h20 + i), 1'b0, 1'b1);
    end
    check("stall_full_no_ovf", 32'(rl0), 5'b00010);
    send_byte(0, 8'h25, 1'b0, 1'b1);
    check("stall_overflow", 32'(rl0), 5'b10010);
    release dut.pop_stall;
    wait_drain(0, 1000);
    check("stall_echo_count", 32'(echo_cnt[0] - e0), 5);
    check("stall_status", 32'(rl0), 5'b10001);

    // Even parity: 0x03 with parity bit 1 is rejected
    e1 = echo_cnt[1];
    send_byte(1, 8'h03, 1'b1, 1'b1);
    repeat (150) @(negedge clk);
    check("parity_err_flag", 32'(rl1), 5'b00101);
    check("parity_left_leds", 32'(ll1), 0);
    check("parity_no_echo", 32'(echo_cnt[1] - e1), 0);
    exp_q1.push_back(8'h07);
    send_byte(1, 8'h07, 1'b0, 1'b1);
    wait_drain(1, 300);
    check("parity_good_echo", 32'(echo_cnt[1] - e1), 1);
    check("parity_good_leds", 32'(ll1), 8'h07);
    check("parity_err_sticky", 32'(rl1), 5'b00101);

    // Glitch: 3 low cycles stay in IDLE with no new flags
    set_rx(1, 1'b0);
    repeat (3) @(negedge clk);
    set_rx(1, 1'b1);
    repeat (20) @(negedge clk);
    check("glitch_rx_state", 32'(rs1), 0);
    check("glitch_status", 32'(rl1), 5'b00101);

    // Stop bit 0 on 0x55, then a 30-bit-time break
    e0 = echo_cnt[0];
    send_byte(0, 8'h55, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    check("frame_err_flag", 32'(rl0), 5'b11001);
    set_rx(0, 1'b0);
    repeat (300) @(negedge clk);
    check("break_held_state", 32'(rs0), 5);
    set_rx(0, 1'b1);
    repeat (50) @(negedge clk);
    check("break_release_idle", 32'(rs0), 0);
    check("break_no_echo", 32'(echo_cnt[0] - e0), 0);
    exp_q0.push_back(8'h5A);
    send_byte(0, 8'h5A, 1'b0, 1'b1);
    wait_drain(0, 300);
    check("after_break_leds", 32'(ll0), 8'h5A);
    check("after_break_status", 32'(rl0), 5'b11001);

    // Reset during the data bits of an 0xFF echo
    exp_q0.push_back(8'hFF);
    send_byte(0, 8'hFF, 1'b0, 1'b1);
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_tx_pin", 32'(tx0), 1);
    check("rst_mid_status", 32'(rl0), 5'b00001);
    check("rst_mid_leds", 32'(ll0), 0);
    check("rst_mid_tx_state", 32'(ts0), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_drain(0, 300);
    exp_q0.push_back(8'h3C);
    send_byte(0, 8'h3C, 1'b0, 1'b1);
    wait_drain(0, 300);
    check("post_reset_leds", 32'(ll0), 8'h3C);
    check("post_reset_status", 32'(rl0), 5'b00001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
